// File: rtl/trigger_pkg.sv
// Shared encodings for the oscilloscope edge trigger.
// State, mode and slope values match the register-visible encodings.
package trigger_pkg;

    typedef enum logic [1:0] {
        ST_ARMING  = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DONE    = 2'd3
    } trigState_e;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_AUTO   = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/trigger_bounds.sv
// Saturating hysteresis bounds around the trigger threshold.
// Purely combinational; low clamps at zero, high clamps at full scale.
module trigger_bounds #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic [DATA_WIDTH-1:0] hysteresis,
    output logic [DATA_WIDTH-1:0] lowBound,
    output logic [DATA_WIDTH-1:0] highBound
);

    logic [DATA_WIDTH:0] sum;

    assign sum = {1'b0, threshold} + {1'b0, hysteresis};

    assign lowBound  = (threshold > hysteresis) ? (threshold - hysteresis) : '0;
    assign highBound = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];

endmodule

// File: rtl/edge_trigger_controller.sv
// Edge trigger with hysteresis arming, holdoff and normal/auto/single modes.
// Watches one channel of a packed sample stream; pulses isTriggered once per event.
module edge_trigger_controller
    import trigger_pkg::*;
#(
    parameter  int DATA_WIDTH    = 8,
    parameter  int CHANNELS      = 2,
    parameter  int HOLDOFF_WIDTH = 16,
    parameter  int TIMEOUT_WIDTH = 20,
    localparam int SEL_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] dataIn,
    input  logic                           dataValid,
    input  logic [SEL_WIDTH-1:0]           channelSelect,
    input  logic [DATA_WIDTH-1:0]          threshold,
    input  logic [DATA_WIDTH-1:0]          hysteresis,
    input  logic                           slope,
    input  logic [1:0]                     mode,
    input  logic                           arm,
    input  logic                           triggerDisable,
    input  logic [HOLDOFF_WIDTH-1:0]       holdoff,
    input  logic [TIMEOUT_WIDTH-1:0]       autoTimeout,
    output logic                           isTriggered,
    output logic                           autoFired,
    output logic                           armed,
    output logic [1:0]                     state,
    output logic [DATA_WIDTH-1:0]          previousData
);

    trigState_e currentState, nextState;

    logic [DATA_WIDTH-1:0]    sample;
    logic [DATA_WIDTH-1:0]    lowBound, highBound;
    logic [SEL_WIDTH-1:0]     prevChannel;
    logic                     prevSlope;
    logic [HOLDOFF_WIDTH-1:0] holdCount, holdNext;
    logic [TIMEOUT_WIDTH-1:0] timeoutCount, timeoutNext;
    logic                     configChange, rising;
    logic                     armCond, crossCond;
    logic                     realFire, autoHit, fire, forced;
    logic                     hunting;

    trigger_bounds #(.DATA_WIDTH(DATA_WIDTH)) bounds (
        .threshold (threshold),
        .hysteresis(hysteresis),
        .lowBound  (lowBound),
        .highBound (highBound)
    );

    // Unmatched select values fall back to channel 0.
    always_comb begin
        sample = dataIn[DATA_WIDTH-1:0];
        for (int k = 0; k < CHANNELS; k++) begin
            if (SEL_WIDTH'(k) == channelSelect) begin
                sample = dataIn[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign configChange = (channelSelect != prevChannel) || (slope != prevSlope);
    assign rising       = (slope == SLOPE_RISING);
    assign armCond      = rising ? (sample < lowBound) : (sample > highBound);
    assign crossCond    = rising ? (sample >= threshold) : (sample <= threshold);
    assign hunting      = (currentState == ST_ARMING) || (currentState == ST_ARMED);
    assign holdNext     = holdCount + 1'b1;
    assign timeoutNext  = timeoutCount + 1'b1;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            currentState <= ST_ARMING;
        end else begin
            currentState <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = currentState;
        if (triggerDisable || configChange) begin
            nextState = ST_ARMING;
        end else begin
            unique case (currentState)
                ST_ARMING: begin
                    if (fire) begin
                        nextState = (mode == MODE_SINGLE) ? ST_DONE : ST_HOLDOFF;
                    end else if (dataValid && armCond) begin
                        nextState = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (fire) begin
                        nextState = (mode == MODE_SINGLE) ? ST_DONE : ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (holdoff == '0) begin
                        nextState = ST_ARMING;
                    end else if (dataValid && (holdNext >= holdoff)) begin
                        nextState = ST_ARMING;
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        nextState = ST_ARMING;
                    end
                end
            endcase
        end
    end

    // Output decode: a real crossing outranks the auto timeout.
    always_comb begin
        realFire = (currentState == ST_ARMED) && crossCond;
        autoHit  = (mode == MODE_AUTO) && (autoTimeout != '0) && hunting
                   && (timeoutNext >= autoTimeout);
        fire     = dataValid && !triggerDisable && !configChange
                   && (realFire || autoHit);
        forced   = fire && !realFire;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            holdCount    <= '0;
            timeoutCount <= '0;
            prevChannel  <= '0;
            prevSlope    <= SLOPE_RISING;
            isTriggered  <= 1'b0;
            autoFired    <= 1'b0;
            armed        <= 1'b0;
            previousData <= '0;
        end else begin
            prevChannel <= channelSelect;
            prevSlope   <= slope;
            isTriggered <= fire;
            autoFired   <= forced;
            armed       <= (nextState == ST_ARMED);
            if (dataValid) begin
                previousData <= sample;
            end
            if (triggerDisable || configChange) begin
                holdCount    <= '0;
                timeoutCount <= '0;
            end else begin
                if ((nextState == ST_ARMING) && (currentState != ST_ARMING)) begin
                    timeoutCount <= '0;
                end else if (dataValid && hunting) begin
                    timeoutCount <= timeoutNext;
                end
                if (currentState != ST_HOLDOFF) begin
                    holdCount <= '0;
                end else if (dataValid) begin
                    holdCount <= holdNext;
                end
            end
        end
    end

    assign state = currentState;

endmodule

// File: doc/edge_trigger_controller.md
# edge_trigger_controller

Parametrised oscilloscope trigger that watches one selected channel of an N-channel sample stream and emits a single-cycle trigger pulse on a rising or falling threshold crossing. It adds hysteresis-qualified arming, a holdoff window, and normal/auto/single acquisition modes. It sits between the ADC sample front end and the capture buffer write controller, which starts post-trigger capture on `isTriggered`.

## Interface
- `DATA_WIDTH`, 8, sample and threshold width
- `CHANNELS`, 2, number of input channels (≥1)
- `HOLDOFF_WIDTH`, 16, width of holdoff counter
- `TIMEOUT_WIDTH`, 20, width of auto-mode timeout counter

Ports:
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `dataIn`  in  CHANNELS*DATA_WIDTH  packed unsigned samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `dataValid`  in  1  qualifies `dataIn` this cycle
- `channelSelect`  in  max(1,$clog2(CHANNELS))  trigger source channel
- `threshold`  in  DATA_WIDTH  trigger level
- `hysteresis`  in  DATA_WIDTH  arming margin
- `slope`  in  1  0 = rising, 1 = falling
- `mode`  in  2  0 = normal, 1 = auto, 2 = single, 3 = treated as normal
- `arm`  in  1  single-cycle pulse; re-arms from DONE
- `triggerDisable`  in  1  suppresses triggering
- `holdoff`  in  HOLDOFF_WIDTH  valid samples ignored after a trigger
- `autoTimeout`  in  TIMEOUT_WIDTH  valid samples before forced trigger in auto mode
- `isTriggered`  out  1  one-cycle trigger pulse
- `autoFired`  out  1  high with `isTriggered` when the pulse was forced
- `armed`  out  1  high in state ARMED
- `state`  out  2  current state encoding
- `previousData`  out  DATA_WIDTH  last valid sample of selected channel

## Operation
- States: ARMING (0), ARMED (1), HOLDOFF (2), DONE (3). Reset → ARMING; all outputs 0.
- Bounds: `low = threshold - hysteresis` saturating at 0; `high = threshold + hysteresis` saturating at 2^DATA_WIDTH-1.
- ARMING: on a valid sample s, rising: s < low → ARMED; falling: s > high → ARMED. With hysteresis 0 and threshold 0 (rising) the condition is never met; that is required.
- ARMED: on a valid sample s, rising: s ≥ threshold fires; falling: s ≤ threshold fires. Fire → pulse, then HOLDOFF (single mode: DONE).
- HOLDOFF: counts valid samples; after `holdoff` samples → ARMING. `holdoff` = 0 → ARMING on the next cycle.
- DONE: holds until `arm` pulse → ARMING. `arm` in other states ignored.
- Auto mode: timeout counter clears on entry to ARMING, counts valid samples in ARMING/ARMED; on reaching `autoTimeout` (nonzero) fires with `autoFired`=1. A real crossing on the same sample wins (`autoFired`=0). `autoTimeout` = 0 disables forcing.
- `triggerDisable` high: no pulse; state forced to ARMING, counters cleared. Takes priority over every other event.
- `channelSelect` or `slope` change (registered compare): state → ARMING, same cycle as the change is seen. Out-of-range `channelSelect` selects channel 0.
- `previousData` updates on every valid sample of the selected channel, in all states.

## Timing
- All outputs registered. `isTriggered` rises the cycle after the clock edge sampling the qualifying `dataIn`/`dataValid`; width exactly one cycle.
- Arming needs at least one sample; the earliest fire is the second valid sample after entering ARMING.
- Invalid cycles (`dataValid`=0) never change state or counters, except `triggerDisable`, config change, and `arm`.
- `reset` mid-operation: immediate return to ARMING, outputs 0, counters 0.

## Structure
- Package `trigger_pkg`: state encodings, mode encodings (MODE_NORMAL/AUTO/SINGLE), slope constants.
- Sub-module `trigger_bounds`: combinational saturating low/high computation, parametrised by DATA_WIDTH.
- Top holds the channel mux, FSM, holdoff and timeout counters.

## Test plan
- Rising, threshold 0x81, hysteresis 4, holdoff 0: samples 0x70,0x80,0x81 → armed after 0x70, one pulse after 0x81, state back to ARMING.
- Noise immunity: threshold 0x81, hysteresis 4, samples 0x80,0x82,0x7F,0x83 after one trigger → no second pulse (0x7F not below 0x7D).
- Falling, channel 1, threshold 0x40, hysteresis 2: ch1 0x50,0x41,0x40 while ch0 toggles 0x00/0xFF → single pulse after 0x40.
- Auto mode, autoTimeout 5, constant samples 0x10, threshold 0x80 → pulse with `autoFired`=1 on 5th valid sample, repeats after holdoff.
- Single mode: trigger → DONE, further crossings ignored; `arm` pulse → ARMING, next crossing fires.
- `triggerDisable` asserted during ARMED on the crossing sample, and `reset` in HOLDOFF → no pulse; state ARMING, outputs 0.
